// File: rtl/uart_transmitter_if.sv
// Byte producer handshake into the UART transmitter: producer drives data/data_valid,
// transmitter answers with data_ready (not full).
interface uart_transmitter_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO; a byte accepted into an idle, empty unit starts
// its start bit on the next edge. data_ready drops while the FIFO is full; offers then are ignored.
module uart_transmitter #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_transmitter_if.slave  bus,
    output logic               TxD,
    output logic               busy
);
    localparam int CNT_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW      = $clog2(CNT_DIV);
    localparam int PW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_nxt_state;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic [2:0]      r_bit, w_nxt_bit;
    logic [7:0]      r_shift, w_nxt_shift;
    logic            r_txd, w_nxt_txd;
    logic            r_busy;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PW:0]     r_count, w_nxt_count;

    logic            w_push, w_load, w_bit_end, w_nonempty;

    assign bus.data_ready = (r_count != (PW+1)'(FIFO_DEPTH));
    assign w_push         = bus.data_valid & bus.data_ready;
    assign w_nonempty     = (r_count != '0);
    assign w_bit_end      = (r_cnt == CW'(CNT_DIV - 1));
    assign TxD            = r_txd;
    assign busy           = r_busy;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.data;
    end

    always_comb begin
        w_nxt_count = r_count;
        case ({w_push, w_load})
            2'b10:   w_nxt_count = r_count + (PW+1)'(1);
            2'b01:   w_nxt_count = r_count - (PW+1)'(1);
            default: w_nxt_count = r_count;
        endcase
    end

    // Frame load (pop) happens from IDLE or at the final edge of STOP, so frames abut with no gap.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = w_bit_end ? '0 : r_cnt + CW'(1);
        w_nxt_bit   = r_bit;
        w_nxt_shift = r_shift;
        w_nxt_txd   = r_txd;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt_cnt = '0;
                w_nxt_txd = 1'b1;
                if (w_nonempty) begin
                    w_load      = 1'b1;
                    w_nxt_state = START;
                    w_nxt_shift = r_mem[r_rd_ptr];
                    w_nxt_bit   = '0;
                    w_nxt_txd   = 1'b0;
                end
            end
            START: begin
                w_nxt_txd = 1'b0;
                if (w_bit_end) begin
                    w_nxt_state = DATA;
                    w_nxt_txd   = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_nxt_shift = {1'b0, r_shift[7:1]};
                    w_nxt_bit   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_nxt_state = STOP;
                        w_nxt_txd   = 1'b1;
                    end else begin
                        w_nxt_txd   = r_shift[1];
                    end
                end
            end
            STOP: begin
                w_nxt_txd = 1'b1;
                if (w_bit_end) begin
                    if (w_nonempty) begin
                        w_load      = 1'b1;
                        w_nxt_state = START;
                        w_nxt_shift = r_mem[r_rd_ptr];
                        w_nxt_bit   = '0;
                        w_nxt_txd   = 1'b0;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_txd   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_bit   <= w_nxt_bit;
            r_shift <= w_nxt_shift;
            r_txd   <= w_nxt_txd;
            // Computed from next-state values so busy is a clean flop output.
            r_busy  <= (w_nxt_state != IDLE) | (w_nxt_count != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_nxt_count;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CNT_DIV=10 with a line-sampling receiver and byte scoreboard.
module tb_uart_transmitter;
    logic clk;
    logic rst_n;
    logic TxD;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    logic [7:0] exp_q[$];
    int         fall_q[$];

    uart_transmitter_if u_if();

    uart_transmitter #(
        .CLK_FREQ  (100_000),
        .BAUD_RATE (10_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if),
        .TxD  (TxD),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: samples mid-bit at the negedge, pops the scoreboard at the stop bit.
    logic       rx_act  = 1'b0;
    logic       rx_prev = 1'b1;
    int         rx_j    = 0;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act  = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_act) begin
                if (rx_prev && (TxD === 1'b0)) begin
                    rx_act = 1'b1;
                    rx_j   = 0;
                    fall_q.push_back(cyc);
                end
            end else begin
                rx_j++;
            end
            if (rx_act) begin
                if (rx_j == 5) begin
                    chk("rx_start_bit", {31'd0, TxD}, 32'd0);
                end else if ((rx_j % 10 == 5) && (rx_j < 95)) begin
                    rx_byte[3'((rx_j / 10) - 1)] = TxD;
                end else if (rx_j == 95) begin
                    chk("rx_stop_bit", {31'd0, TxD}, 32'd1);
                    chk("sb_byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        rx_exp = exp_q.pop_front();
                        chk("rx_byte", {24'd0, rx_byte}, {24'd0, rx_exp});
                    end
                    rx_act = 1'b0;
                end
            end
            rx_prev = TxD;
        end
    end

    // Offer one byte for one clock; the bench states whether it must be accepted.
    task automatic offer(input logic [7:0] b, input logic accept);
        u_if.data       = b;
        u_if.data_valid = 1'b1;
        chk("data_ready", {31'd0, u_if.data_ready}, {31'd0, accept});
        if (accept) exp_q.push_back(b);
        @(posedge clk); #1;
        u_if.data_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] fb;
        int bad = 0;
        int bbad = 0;
        fb = {1'b1, b, 1'b0};
        for (int c = 0; c < 100; c++) begin
            if (TxD !== fb[c / 10]) bad++;
            if (busy !== 1'b1) bbad++;
            @(posedge clk); #1;
        end
        chk({tag, "_line_bits"}, bad, 0);
        chk({tag, "_busy_in_frame"}, bbad, 0);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while ((busy !== 1'b0) && (n < limit)) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int bad;
        rst_n           = 1'b0;
        u_if.data       = 8'h00;
        u_if.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", {31'd0, TxD}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, u_if.data_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte 0xA5
        offer(8'hA5, 1'b1);
        chk("a5_txd_at_accept", {31'd0, TxD}, 32'd1);
        chk("a5_busy_at_accept", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        expect_frame(8'hA5, "a5");
        chk("a5_txd_after", {31'd0, TxD}, 32'd1);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);

        // Three bytes in consecutive cycles
        fall_q.delete();
        offer(8'h00, 1'b1);
        acc = cyc;
        offer(8'hFF, 1'b1);
        offer(8'h55, 1'b1);
        repeat (298) begin @(posedge clk); #1; end
        chk("x3_busy_last", {31'd0, busy}, 32'd1);
        chk("x3_txd_last", {31'd0, TxD}, 32'd1);
        @(posedge clk); #1;
        chk("x3_busy_done", {31'd0, busy}, 32'd0);
        chk("x3_frames", fall_q.size(), 3);
        if (fall_q.size() >= 3) begin
            chk("x3_fall0", fall_q[0], acc + 1);
            chk("x3_fall1", fall_q[1], acc + 101);
            chk("x3_fall2", fall_q[2], acc + 201);
        end

        // Six offers while the first frame runs: fifth is the last accepted
        offer(8'h11, 1'b1);
        offer(8'h22, 1'b1);
        offer(8'h33, 1'b1);
        offer(8'h44, 1'b1);
        offer(8'h55, 1'b1);
        offer(8'h66, 1'b0);
        chk("full_ready_low", {31'd0, u_if.data_ready}, 32'd0);
        wait_idle(700, "full_drain");
        chk("full_sb_empty", exp_q.size(), 0);

        // Push coinciding with the STOP-end pop while two bytes are queued
        offer(8'hC1, 1'b1);
        offer(8'hC2, 1'b1);
        offer(8'hC3, 1'b1);
        repeat (98) begin @(posedge clk); #1; end
        chk("pp_txd_stop_end", {31'd0, TxD}, 32'd1);
        offer(8'hC4, 1'b1);
        chk("pp_txd_next_start", {31'd0, TxD}, 32'd0);
        offer(8'hC5, 1'b1);
        offer(8'hC6, 1'b1);
        offer(8'hC7, 1'b0);
        wait_idle(800, "pp_drain");
        chk("pp_sb_empty", exp_q.size(), 0);

        // Reset at clock 35 of a frame, in data bit 2 (0 for 0x3A)
        offer(8'h3A, 1'b1);
        offer(8'h77, 1'b1);
        repeat (35) begin @(posedge clk); #1; end
        chk("mr_txd_before", {31'd0, TxD}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_txd", {31'd0, TxD}, 32'd1);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_ready", {31'd0, u_if.data_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            if ((TxD !== 1'b1) || (busy !== 1'b0)) bad++;
            @(posedge clk); #1;
        end
        chk("mr_quiet_after", bad, 0);

        // Back-to-back 0x80, 0x01: second start exactly one frame after the first
        fall_q.delete();
        offer(8'h80, 1'b1);
        offer(8'h01, 1'b1);
        wait_idle(400, "bb_drain");
        chk("bb_frames", fall_q.size(), 2);
        if (fall_q.size() >= 2) chk("bb_gap", fall_q[1] - fall_q[0], 100);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
